// File: rtl/lvds_33_rx_pkg.sv
// Shared types and constants for the LVDS_33 receive deserializer.
// Pair checking is compiled in with LVDS_33_RX_PAIR_CHECK_EN.
package lvds_33_rx_pkg;

  typedef enum logic [1:0] {
    S_HUNT    = 2'd0,
    S_CONFIRM = 2'd1,
    S_LOCKED  = 2'd2
  } rx_state_e;

  localparam logic [7:0]  SYNC_DEFAULT = 8'hA5;
  localparam int unsigned MC_W         = 4;

endpackage

// File: rtl/lvds_33_rx_deser_if.sv
// Pad-side pair and parallel word output of the LVDS_33 receive deserializer.
// Same bundle whether or not LVDS_33_RX_PAIR_CHECK_EN is defined.
interface lvds_33_rx_deser_if #(
  parameter int unsigned WIDTH = 8
);
  logic             I;
  logic             IB;
  logic [WIDTH-1:0] Q;
  logic             QV;
  logic             LOCKED;
  logic             ERR;

  modport master (output I, IB, input Q, QV, LOCKED, ERR);
  modport slave  (input I, IB, output Q, QV, LOCKED, ERR);
endinterface

// File: rtl/lvds_33_rx_sample.sv
// Input stage: registers the differential pair into a data bit and a pair-valid flag.
// With LVDS_33_RX_PAIR_CHECK_EN undefined, IB is ignored and the pair is always valid.
module lvds_33_rx_sample (
  input  logic C,
  input  logic R,
  input  logic I,
  input  logic IB,
  output logic b,
  output logic v
);

`ifdef LVDS_33_RX_PAIR_CHECK_EN
  // v is registered from the same edge as b, so it equals (I_r != IB_r)
  always_ff @(posedge C) begin
    if (R) begin
      b <= 1'b0;
      v <= 1'b0;
    end else begin
      b <= I;
      v <= (I != IB);
    end
  end
`else
  logic unused_ib;
  assign unused_ib = IB;

  always_ff @(posedge C) begin
    if (R) begin
      b <= 1'b0;
      v <= 1'b1;
    end else begin
      b <= I;
      v <= 1'b1;
    end
  end
`endif

endmodule

// File: rtl/lvds_33_rx_deser.sv
// LVDS_33 receive deserializer: sync-word framer delivering aligned WIDTH-bit words.
// Define LVDS_33_RX_PAIR_CHECK_EN to drop lock and pulse ERR on an undriven/invalid pair.
module lvds_33_rx_deser
  import lvds_33_rx_pkg::*;
#(
  parameter int unsigned      WIDTH      = 8,
  parameter logic [WIDTH-1:0] SYNC       = WIDTH'(SYNC_DEFAULT),
  parameter int unsigned      LOCK_COUNT = 2
) (
  input logic                C,
  input logic                R,
  lvds_33_rx_deser_if.slave  bus
);

`ifdef LVDS_33_RX_PAIR_CHECK_EN
  localparam bit PAIR_CHECK = 1'b1;
`else
  localparam bit PAIR_CHECK = 1'b0;
`endif

  localparam int unsigned     BC_W    = $clog2(WIDTH);
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(WIDTH - 1);
  localparam logic [MC_W-1:0] MC_LOCK = MC_W'(LOCK_COUNT);

  logic             b;
  logic             v;
  rx_state_e        state, state_nxt;
  logic [WIDTH-1:0] sr;
  logic [BC_W-1:0]  bc, bc_nxt;
  logic [MC_W-1:0]  mc, mc_nxt, mc_inc;
  logic [WIDTH-1:0] q_r, q_nxt;
  logic             qv_r, qv_nxt;
  logic             locked_r;
  logic             err_r, err_nxt;
  logic             wrap;
  logic             match;
  logic             pair_bad;

  lvds_33_rx_sample u_sample (
    .C  (C),
    .R  (R),
    .I  (bus.I),
    .IB (bus.IB),
    .b  (b),
    .v  (v)
  );

  assign wrap     = (bc == BC_LAST);
  assign match    = (sr == SYNC);
  assign pair_bad = PAIR_CHECK && !v;
  assign mc_inc   = mc + MC_W'(1);

  // State register plus shift register, counters and registered outputs
  always_ff @(posedge C) begin
    if (R) begin
      state    <= S_HUNT;
      sr       <= '0;
      bc       <= '0;
      mc       <= '0;
      q_r      <= '0;
      qv_r     <= 1'b0;
      locked_r <= 1'b0;
      err_r    <= 1'b0;
    end else begin
      state    <= state_nxt;
      sr       <= {sr[WIDTH-2:0], b};
      bc       <= bc_nxt;
      mc       <= mc_nxt;
      q_r      <= q_nxt;
      qv_r     <= qv_nxt;
      locked_r <= (state_nxt == S_LOCKED);
      err_r    <= err_nxt;
    end
  end

  // Framer next-state and output decode
  always_comb begin
    state_nxt = state;
    bc_nxt    = wrap ? '0 : bc + BC_W'(1);
    mc_nxt    = mc;
    q_nxt     = q_r;
    qv_nxt    = 1'b0;
    err_nxt   = 1'b0;

    case (state)
      S_HUNT: begin
        if (!pair_bad && match) begin
          bc_nxt    = '0;
          mc_nxt    = MC_W'(1);
          state_nxt = (LOCK_COUNT == 1) ? S_LOCKED : S_CONFIRM;
        end
      end

      S_CONFIRM: begin
        if (pair_bad) begin
          state_nxt = S_HUNT;
          mc_nxt    = '0;
        end else if (wrap) begin
          if (match) begin
            if (mc_inc >= MC_LOCK) begin
              mc_nxt    = MC_LOCK;
              state_nxt = S_LOCKED;
            end else begin
              mc_nxt = mc_inc;
            end
          end else begin
            state_nxt = S_HUNT;
            mc_nxt    = '0;
          end
        end
      end

      S_LOCKED: begin
        // An invalid pair discards the partial word and restarts the hunt
        if (pair_bad) begin
          state_nxt = S_HUNT;
          bc_nxt    = '0;
          mc_nxt    = '0;
          err_nxt   = 1'b1;
        end else if (wrap) begin
          q_nxt  = sr;
          qv_nxt = 1'b1;
        end
      end

      default: begin
        state_nxt = S_HUNT;
        mc_nxt    = '0;
      end
    endcase
  end

  assign bus.Q      = q_r;
  assign bus.QV     = qv_r;
  assign bus.LOCKED = locked_r;
  assign bus.ERR    = err_r;

endmodule

// File: tb/tb_lvds_33_rx_deser.sv
// Scoreboard bench for lvds_33_rx_deser (WIDTH=8, SYNC=A5, LOCK_COUNT=2).
// Expectations adapt to LVDS_33_RX_PAIR_CHECK_EN when the bench is built with it.
module tb_lvds_33_rx_deser;

  localparam int unsigned WIDTH = 8;

  typedef struct {
    logic [7:0] data;
    int         cyc;
  } wexp_t;

  logic C = 1'b0;
  logic R = 1'b1;

  lvds_33_rx_deser_if #(.WIDTH(WIDTH)) bus ();

  lvds_33_rx_deser #(
    .WIDTH      (WIDTH),
    .SYNC       (8'hA5),
    .LOCK_COUNT (2)
  ) dut (
    .C   (C),
    .R   (R),
    .bus (bus)
  );

  always #5 C = ~C;

  wexp_t word_q[$];
  int    lock_cyc_q[$];
  logic  lock_val_q[$];
  int    err_q[$];

  int   cyc       = 0;
  logic r_q       = 1'b0;
  bit   done      = 1'b0;
  bit   tb_locked = 1'b0;
  int   errors    = 0;
  int   checks    = 0;

  always @(posedge C) begin
    cyc <= cyc + 1;
    r_q <= R;
  end

  // Drive one bit before the next edge; returns the number of the edge that samples it
  task automatic send_bit(input logic b, input bit glitch, output int edge_no);
    @(negedge C);
    bus.I   = glitch ? 1'b1 : b;
    bus.IB  = glitch ? 1'b1 : ~b;
    edge_no = cyc + 1;
  endtask

  task automatic idle(input int n);
    int e;
    for (int i = 0; i < n; i++) send_bit(1'b0, 1'b0, e);
  endtask

  // kind: 0 = no output, 1 = completes lock, 2 = delivered as data
  task automatic send_word(input logic [7:0] w, input int kind, input int gidx);
    int         e;
    logic [7:0] got;
    got = w;
    for (int i = 7; i >= 0; i--) begin
      send_bit(w[i], (i == gidx), e);
      if (i == gidx) begin
        got[i] = 1'b1;
`ifdef LVDS_33_RX_PAIR_CHECK_EN
        if (tb_locked) begin
          err_q.push_back(e + 1);
          lock_cyc_q.push_back(e + 1);
          lock_val_q.push_back(1'b0);
          tb_locked = 1'b0;
        end
`endif
      end
    end
    if (kind == 1) begin
      lock_cyc_q.push_back(e + 2);
      lock_val_q.push_back(1'b1);
      tb_locked = 1'b1;
    end else if (kind == 2) begin
      word_q.push_back('{data: got, cyc: e + 2});
    end
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge C);
      R      = 1'b1;
      bus.I  = 1'($urandom_range(0, 1));
      bus.IB = ~bus.I;
      if (i == 0 && tb_locked) begin
        lock_cyc_q.push_back(cyc + 1);
        lock_val_q.push_back(1'b0);
        tb_locked = 1'b0;
      end
    end
    @(negedge C);
    R      = 1'b0;
    bus.I  = 1'b0;
    bus.IB = 1'b1;
  endtask

  // Monitor: every observable event is matched against the scoreboard queues
  logic prev_locked = 1'b0;
  always @(negedge C) begin
    wexp_t wx;
    int    ec;
    logic  ev;
    if (cyc >= 1) begin
      if (bus.LOCKED !== prev_locked) begin
        checks++;
        if (lock_cyc_q.size() == 0) begin
          errors++;
          $display("FAIL lock_change: LOCKED=%b at cycle %0d, no change required", bus.LOCKED, cyc);
        end else begin
          ec = lock_cyc_q.pop_front();
          ev = lock_val_q.pop_front();
          if (bus.LOCKED !== ev || ec != cyc) begin
            errors++;
            $display("FAIL lock_change: LOCKED=%b at cycle %0d, required %b at cycle %0d",
                     bus.LOCKED, cyc, ev, ec);
          end
        end
        prev_locked = bus.LOCKED;
      end
      if (bus.ERR !== 1'b0) begin
        checks++;
        if (err_q.size() == 0) begin
          errors++;
          $display("FAIL err_pulse: ERR=%b at cycle %0d, none required", bus.ERR, cyc);
        end else begin
          ec = err_q.pop_front();
          if (ec != cyc) begin
            errors++;
            $display("FAIL err_pulse: ERR at cycle %0d, required at cycle %0d", cyc, ec);
          end
        end
      end
      if (bus.QV !== 1'b0) begin
        checks++;
        if (word_q.size() == 0) begin
          errors++;
          $display("FAIL word: QV=%b Q=%h at cycle %0d, no word required", bus.QV, bus.Q, cyc);
        end else begin
          wx = word_q.pop_front();
          if (bus.Q !== wx.data || wx.cyc != cyc) begin
            errors++;
            $display("FAIL word: Q=%h at cycle %0d, required %h at cycle %0d",
                     bus.Q, cyc, wx.data, wx.cyc);
          end
        end
      end
      if (r_q) begin
        checks++;
        if ({bus.Q, bus.QV, bus.LOCKED, bus.ERR} !== '0) begin
          errors++;
          $display("FAIL reset_outputs: Q=%h QV=%b LOCKED=%b ERR=%b at cycle %0d, required all 0",
                   bus.Q, bus.QV, bus.LOCKED, bus.ERR, cyc);
        end
      end
      if (done) begin
        checks++;
        if (word_q.size() != 0) begin
          errors++;
          $display("FAIL words_pending: %0d outstanding, required 0", word_q.size());
        end
        checks++;
        if (lock_cyc_q.size() != 0) begin
          errors++;
          $display("FAIL lock_pending: %0d outstanding, required 0", lock_cyc_q.size());
        end
        checks++;
        if (err_q.size() != 0) begin
          errors++;
          $display("FAIL err_pending: %0d outstanding, required 0", err_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, required completion by 100000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int e;
    bus.I  = 1'b0;
    bus.IB = 1'b1;

    // Reset, then basic lock and data delivery
    do_reset(3);
    idle(3);
    send_word(8'hA5, 0, -1);
    send_word(8'hA5, 1, -1);
    send_word(8'h3C, 2, -1);
    send_word(8'hC3, 2, -1);
    idle(2);

    // False sync: mismatch in CONFIRM returns to HUNT
    do_reset(3);
    send_word(8'hA5, 0, -1);
    send_word(8'h00, 0, -1);
    send_word(8'hA5, 0, -1);
    send_word(8'hA5, 1, -1);
    send_word(8'h11, 2, -1);
    idle(2);

    // Pair fault mid-word while locked
    do_reset(3);
    send_word(8'hA5, 0, -1);
    send_word(8'hA5, 1, -1);
    send_word(8'h3C, 2, -1);
`ifdef LVDS_33_RX_PAIR_CHECK_EN
    send_word(8'h00, 0, 4);
    send_word(8'hA5, 0, -1);
    send_word(8'hA5, 1, -1);
`else
    send_word(8'h00, 2, 4);
    send_word(8'hA5, 2, -1);
    send_word(8'hA5, 2, -1);
`endif
    send_word(8'h5A, 2, -1);
    idle(2);

    // Reset on the edge where a word would be delivered
    do_reset(3);
    send_word(8'hA5, 0, -1);
    send_word(8'hA5, 1, -1);
    send_word(8'h3C, 2, -1);
    send_word(8'h96, 0, -1);
    send_bit(1'b0, 1'b0, e);
    do_reset(2);
    send_word(8'hA5, 0, -1);
    send_word(8'hA5, 1, -1);
    send_word(8'h42, 2, -1);
    idle(2);

    do_reset(2);
    done = 1'b1;
  end

endmodule
